pipeline_hazard_ctrl: RTL and testbench

Central stall/flush/forward controller for the 5-stage RISC-V datapath. It drives the enable and bubble-insert controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC enable. It detects register hazards and applies taken-branch flushes. It also sequences data-memory wait states through a small FSM with a timeout and keeps a saturating stall-cycle counter.

---
 rtl/pipeline_hazard_ctrl_if.sv | 30 +++
 rtl/pipeline_hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bus: decode/execute/memory hazard inputs toward the controller,
// pipeline-register enables, flushes, forwarding selects and status back.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR = 5,
  parameter int CNT_W    = 16
);
  logic [REG_ADDR-1:0] id_rs1, id_rs2, ex_rd, mem_rd;
  logic                id_use_rs1, id_use_rs2;
  logic                ex_reg_write, ex_mem_read, mem_reg_write;
  logic                ex_branch_taken, mem_req, dmem_ready;
  logic                pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic                if_id_flush, id_ex_flush, mem_wb_flush;
  logic [1:0]          fwd_a, fwd_b;
  logic                mem_timeout_err;
  logic [CNT_W-1:0]    stall_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_reg_write, ex_mem_read,
           mem_rd, mem_reg_write, ex_branch_taken, mem_req, dmem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, mem_wb_flush, fwd_a, fwd_b, mem_timeout_err, stall_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_reg_write, ex_mem_read,
           mem_rd, mem_reg_write, ex_branch_taken, mem_req, dmem_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, mem_wb_flush, fwd_a, fwd_b, mem_timeout_err, stall_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage pipeline with data-memory wait FSM.
// Define HAZARD_FWD_EN to compile in operand forwarding (stall only on load-use).
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR    = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int WW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  state_t           state, state_d;
  logic [WW-1:0]    wcnt, wcnt_d, wcnt_nx;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b, hazard;
  logic [1:0] fa, fb;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_fl, id_ex_fl, mem_wb_fl;
  logic apply_pipe, freeze;

  always_comb begin
    ex_hit_a  = hz.id_use_rs1 && (hz.id_rs1 != '0) && hz.ex_reg_write  && (hz.ex_rd  == hz.id_rs1);
    ex_hit_b  = hz.id_use_rs2 && (hz.id_rs2 != '0) && hz.ex_reg_write  && (hz.ex_rd  == hz.id_rs2);
    mem_hit_a = hz.id_use_rs1 && (hz.id_rs1 != '0) && hz.mem_reg_write && (hz.mem_rd == hz.id_rs1);
    mem_hit_b = hz.id_use_rs2 && (hz.id_rs2 != '0) && hz.mem_reg_write && (hz.mem_rd == hz.id_rs2);
`ifdef HAZARD_FWD_EN
    hazard = (ex_hit_a || ex_hit_b) && hz.ex_mem_read;
    fa     = ex_hit_a ? 2'b10 : (mem_hit_a ? 2'b01 : 2'b00);
    fb     = ex_hit_b ? 2'b10 : (mem_hit_b ? 2'b01 : 2'b00);
`else
    // Without forwarding any in-flight producer must drain; WB writes early in the cycle.
    hazard = ex_hit_a || ex_hit_b || mem_hit_a || mem_hit_b;
    fa     = 2'b00;
    fb     = 2'b00;
`endif
  end

  assign wcnt_nx = wcnt + 1'b1;

  always_comb begin
    state_d    = state;
    wcnt_d     = wcnt;
    apply_pipe = 1'b0;
    freeze     = 1'b0;
    pc_en      = 1'b1;
    if_id_en   = 1'b1;
    id_ex_en   = 1'b1;
    ex_mem_en  = 1'b1;
    mem_wb_en  = 1'b1;
    if_id_fl   = 1'b0;
    id_ex_fl   = 1'b0;
    mem_wb_fl  = 1'b0;
    case (state)
      RUN: begin
        if (hz.mem_req && !hz.dmem_ready) begin
          freeze  = 1'b1;
          wcnt_d  = WW'(1);
          state_d = (MEM_TIMEOUT <= 1) ? ERR : MEM_WAIT;
        end else begin
          apply_pipe = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (hz.dmem_ready) begin
          apply_pipe = 1'b1;
          wcnt_d     = '0;
          state_d    = RUN;
        end else begin
          freeze = 1'b1;
          wcnt_d = wcnt_nx;
          if (wcnt_nx == WW'(MEM_TIMEOUT)) state_d = ERR;
        end
      end
      default: begin
        pc_en     = 1'b0;
        if_id_en  = 1'b0;
        id_ex_en  = 1'b0;
        ex_mem_en = 1'b0;
        mem_wb_en = 1'b0;
      end
    endcase
    // A taken branch squashes the younger instructions, so it outranks the hazard stall.
    if (apply_pipe) begin
      if (hz.ex_branch_taken) begin
        if_id_fl = 1'b1;
        id_ex_fl = 1'b1;
      end else if (hazard) begin
        pc_en    = 1'b0;
        if_id_en = 1'b0;
        id_ex_fl = 1'b1;
      end
    end
    if (freeze) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_fl = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
      wcnt  <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state <= state_d;
      wcnt  <= wcnt_d;
      if (state_d == ERR) err_q <= 1'b1;
      if (state != ERR && !pc_en && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    hz.pc_en           = rst && pc_en;
    hz.if_id_en        = rst && if_id_en;
    hz.id_ex_en        = rst && id_ex_en;
    hz.ex_mem_en       = rst && ex_mem_en;
    hz.mem_wb_en       = rst && mem_wb_en;
    hz.if_id_flush     = !rst || if_id_fl;
    hz.id_ex_flush     = !rst || id_ex_fl;
    hz.mem_wb_flush    = !rst || mem_wb_fl;
    hz.fwd_a           = rst ? fa : 2'b00;
    hz.fwd_b           = rst ? fb : 2'b00;
    hz.mem_timeout_err = err_q;
    hz.stall_cnt       = cnt_q;
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: driver queues hand-computed expectations
// per cycle, a negedge monitor pops and compares against the DUT outputs.
module tb_pipeline_hazard_ctrl;
  localparam int CNT_W = 3;
  localparam int TO    = 4;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [4:0] EN_ALL = 5'b11111, EN_HZ = 5'b00111, EN_FRZ = 5'b00001, EN_OFF = 5'b00000;
  localparam logic [2:0] FL_NONE = 3'b000, FL_HZ = 3'b010, FL_BR = 3'b110, FL_FRZ = 3'b001, FL_RST = 3'b111;

  typedef struct {
    string            nm;
    logic [4:0]       en;
    logic [2:0]       fl;
    logic [3:0]       fwd;
    logic             err;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  logic             m_err;
  logic [CNT_W-1:0] m_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_ADDR(5), .CNT_W(CNT_W)) bus ();
  pipeline_hazard_ctrl #(.REG_ADDR(5), .MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .hz(bus)
  );

  task automatic chk(input string nm, input string fld, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s actual=%h expected=%h", nm, fld, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.nm, "en", 16'({bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en}), 16'(e.en));
      chk(e.nm, "flush", 16'({bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_flush}), 16'(e.fl));
      chk(e.nm, "fwd", 16'({bus.fwd_a, bus.fwd_b}), 16'(e.fwd));
      chk(e.nm, "err", 16'(bus.mem_timeout_err), 16'(e.err));
      chk(e.nm, "stall_cnt", 16'(bus.stall_cnt), 16'(e.cnt));
    end
  end

  task automatic clr();
    rst = 1'b1;
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;
    bus.ex_rd = '0; bus.ex_reg_write = 0; bus.ex_mem_read = 0;
    bus.mem_rd = '0; bus.mem_reg_write = 0;
    bus.ex_branch_taken = 0; bus.mem_req = 0; bus.dmem_ready = 0;
  endtask

  task automatic load_use();
    bus.ex_reg_write = 1; bus.ex_mem_read = 1; bus.ex_rd = 5'd5;
    bus.id_rs1 = 5'd5; bus.id_use_rs1 = 1;
  endtask

  // Queue the expectation for the current cycle, advance the spec-level counters, step.
  task automatic cyc(input string nm, input logic [4:0] en, input logic [2:0] fl,
                     input logic [1:0] fa, input logic [1:0] fb, input logic to_err);
    exp_t e;
    e.nm = nm; e.en = en; e.fl = fl; e.fwd = {fa, fb}; e.err = m_err; e.cnt = m_cnt;
    q.push_back(e);
    if (!rst) begin
      m_err = 1'b0;
      m_cnt = '0;
    end else begin
      if (!m_err && !en[4] && m_cnt != '1) m_cnt = m_cnt + 1'b1;
      if (to_err) m_err = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_err = 1'b0;
    m_cnt = '0;
    clr();
    rst = 1'b0;
    @(posedge clk);
    #1;
    bus.mem_req = 1;
    cyc("reset", EN_OFF, FL_RST, 2'b00, 2'b00, 0);
    clr(); cyc("idle", EN_ALL, FL_NONE, 2'b00, 2'b00, 0);

    clr(); load_use();
    cyc("load_use", EN_HZ, FL_HZ, FWD ? 2'b10 : 2'b00, 2'b00, 0);
    clr(); bus.id_rs1 = 5'd5; bus.id_use_rs1 = 1; bus.mem_rd = 5'd5; bus.mem_reg_write = 1;
    cyc("after_lu", FWD ? EN_ALL : EN_HZ, FWD ? FL_NONE : FL_HZ, FWD ? 2'b01 : 2'b00, 2'b00, 0);

    clr(); bus.ex_reg_write = 1; bus.ex_mem_read = 1; bus.ex_rd = '0; bus.id_rs2 = '0; bus.id_use_rs2 = 1;
    cyc("x0", EN_ALL, FL_NONE, 2'b00, 2'b00, 0);
    clr(); bus.ex_reg_write = 1; bus.ex_rd = 5'd7; bus.id_rs2 = 5'd7; bus.id_use_rs2 = 1;
    cyc("ex_alu", FWD ? EN_ALL : EN_HZ, FWD ? FL_NONE : FL_HZ, 2'b00, FWD ? 2'b10 : 2'b00, 0);
    clr(); bus.ex_reg_write = 1; bus.ex_rd = 5'd3; bus.mem_reg_write = 1; bus.mem_rd = 5'd3;
    bus.id_rs1 = 5'd3; bus.id_use_rs1 = 1;
    cyc("ex_over_mem", FWD ? EN_ALL : EN_HZ, FWD ? FL_NONE : FL_HZ, FWD ? 2'b10 : 2'b00, 2'b00, 0);
    clr(); load_use(); bus.id_use_rs1 = 0;
    cyc("no_use", EN_ALL, FL_NONE, 2'b00, 2'b00, 0);
    clr(); load_use(); bus.ex_reg_write = 0;
    cyc("no_write", EN_ALL, FL_NONE, 2'b00, 2'b00, 0);

    clr(); load_use(); bus.ex_branch_taken = 1;
    cyc("br_lu", EN_ALL, FL_BR, FWD ? 2'b10 : 2'b00, 2'b00, 0);

    clr(); bus.mem_req = 1; bus.ex_branch_taken = 1;
    cyc("mw1", EN_FRZ, FL_FRZ, 2'b00, 2'b00, 0);
    bus.ex_branch_taken = 0;
    cyc("mw2", EN_FRZ, FL_FRZ, 2'b00, 2'b00, 0);
    cyc("mw3", EN_FRZ, FL_FRZ, 2'b00, 2'b00, 0);
    bus.dmem_ready = 1;
    cyc("mw_rel", EN_ALL, FL_NONE, 2'b00, 2'b00, 0);

    clr(); bus.mem_req = 1;
    cyc("mwh1", EN_FRZ, FL_FRZ, 2'b00, 2'b00, 0);
    bus.dmem_ready = 1; load_use();
    cyc("mwh_rel_lu", EN_HZ, FL_HZ, FWD ? 2'b10 : 2'b00, 2'b00, 0);
    clr(); bus.mem_req = 1; bus.dmem_ready = 1;
    cyc("mem_fast", EN_ALL, FL_NONE, 2'b00, 2'b00, 0);

    for (int i = 0; i < 8; i++) begin
      clr(); load_use();
      cyc($sformatf("sat%0d", i), EN_HZ, FL_HZ, FWD ? 2'b10 : 2'b00, 2'b00, 0);
    end
    clr(); cyc("sat_hold", EN_ALL, FL_NONE, 2'b00, 2'b00, 0);

    clr(); rst = 1'b0;
    cyc("rst2", EN_OFF, FL_RST, 2'b00, 2'b00, 0);
    clr(); bus.mem_req = 1;
    for (int i = 1; i <= TO; i++)
      cyc($sformatf("to%0d", i), EN_FRZ, FL_FRZ, 2'b00, 2'b00, i == TO);
    cyc("err", EN_OFF, FL_NONE, 2'b00, 2'b00, 0);
    bus.dmem_ready = 1; bus.ex_branch_taken = 1;
    cyc("err_hold", EN_OFF, FL_NONE, 2'b00, 2'b00, 0);
    rst = 1'b0;
    cyc("err_rst", EN_OFF, FL_RST, 2'b00, 2'b00, 0);
    clr(); cyc("after_err", EN_ALL, FL_NONE, 2'b00, 2'b00, 0);

    clr(); bus.mem_req = 1;
    cyc("ms1", EN_FRZ, FL_FRZ, 2'b00, 2'b00, 0);
    cyc("ms2", EN_FRZ, FL_FRZ, 2'b00, 2'b00, 0);
    rst = 1'b0;
    cyc("ms_rst", EN_OFF, FL_RST, 2'b00, 2'b00, 0);
    clr(); cyc("ms_after", EN_ALL, FL_NONE, 2'b00, 2'b00, 0);

    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
